// File: rtl/frame_wr_ctrl.sv
`default_nettype none
// ============================================================================
// frame_wr_ctrl
// Checks AXI4-Stream video framing, packs RGB888 to RGB444, writes the frame
// memory and hands completed frames to the reader through ping-pong banks.
// Revision: 1.0
// ============================================================================
module frame_wr_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst,
   output logic              s_axis_video_tready,
   input  logic [23:0]       s_axis_video_tdata,
   input  logic              s_axis_video_tvalid,
   input  logic              s_axis_video_tuser,
   input  logic              s_axis_video_tlast,
   output logic              mem_we,
   output logic              mem_wbank,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [11:0]       mem_wdata,
   output logic              rd_bank,
   input  logic              rd_frame_done,
   output logic              frame_done,
   output logic              err_pulse,
   output logic [15:0]       err_count,
   output logic              busy
);

   localparam int PIX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DROP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic              full_q, full_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_wbank_q, mem_wbank_d;
   logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
   logic [11:0]       mem_wdata_q, mem_wdata_d;
   logic              frame_done_q, frame_done_d;
   logic              err_pulse_q, err_pulse_d;
   logic [15:0]       err_count_q, err_count_d;

   logic              beat;
   logic              do_write;
   logic              do_err;
   logic              swap;
   logic              eol_pix;
   logic [ADDR_W-1:0] wr_addr;

   // Low nibbles are discarded by the RGB444 packing.
   logic unused_low_bits;
   assign unused_low_bits = ^{s_axis_video_tdata[19:16], s_axis_video_tdata[11:8],
                              s_axis_video_tdata[3:0]};

   assign s_axis_video_tready = ~rst;
   assign beat                = s_axis_video_tvalid & s_axis_video_tready;
   assign eol_pix             = (pix_q == PIX_LAST);

   always_comb begin
      state_d      = state_q;
      pix_d        = pix_q;
      line_d       = line_q;
      addr_d       = addr_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      full_d       = full_q;
      mem_we_d     = 1'b0;
      mem_wbank_d  = mem_wbank_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      frame_done_d = 1'b0;
      err_pulse_d  = 1'b0;
      err_count_d  = err_count_q;
      do_write     = 1'b0;
      do_err       = 1'b0;
      wr_addr      = addr_q;

      // Swap is resolved before the beat so a coincident SOF lands in the new bank.
      swap = rd_frame_done & full_q & (state_q != ACTIVE);
      if (swap) begin
         wr_bank_d = ~wr_bank_q;
         rd_bank_d = ~rd_bank_q;
         full_d    = 1'b0;
      end

      if (beat) begin
         if (s_axis_video_tuser) begin
            if (state_q == ACTIVE) begin
               do_err = 1'b1;
            end else begin
               full_d = 1'b0;
            end
            do_write = 1'b1;
            wr_addr  = '0;
            pix_d    = PIX_W'(1);
            line_d   = '0;
            state_d  = ACTIVE;
         end else if (state_q == ACTIVE) begin
            if (s_axis_video_tlast != eol_pix) begin
               do_err  = 1'b1;
               state_d = DROP;
            end else begin
               do_write = 1'b1;
               if (eol_pix) begin
                  pix_d = '0;
                  if (line_q == LINE_LAST) begin
                     frame_done_d = 1'b1;
                     full_d       = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     line_d = line_q + LINE_W'(1);
                  end
               end else begin
                  pix_d = pix_q + PIX_W'(1);
               end
            end
         end
      end

      if (do_write) begin
         mem_we_d    = 1'b1;
         mem_wbank_d = wr_bank_d;
         mem_waddr_d = wr_addr;
         mem_wdata_d = {s_axis_video_tdata[23:20], s_axis_video_tdata[15:12],
                        s_axis_video_tdata[7:4]};
         addr_d      = wr_addr + ADDR_W'(1);
      end

      if (do_err) begin
         err_pulse_d = 1'b1;
         if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pix_q        <= '0;
         line_q       <= '0;
         addr_q       <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b1;
         full_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wbank_q  <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         frame_done_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         pix_q        <= pix_d;
         line_q       <= line_d;
         addr_q       <= addr_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         full_q       <= full_d;
         mem_we_q     <= mem_we_d;
         mem_wbank_q  <= mem_wbank_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         frame_done_q <= frame_done_d;
         err_pulse_q  <= err_pulse_d;
         err_count_q  <= err_count_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_wbank  = mem_wbank_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign rd_bank    = rd_bank_q;
   assign frame_done = frame_done_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign busy       = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_frame_wr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frame_wr_ctrl
// Directed scenarios plus randomized stream against a frame-index model.
// Revision: 1.0
// ============================================================================
module tb_frame_wr_ctrl;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 4;
   localparam int N  = H * V;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tready;
   logic [23:0]   tdata = '0;
   logic          tvalid = 1'b0;
   logic          tuser = 1'b0;
   logic          tlast = 1'b0;
   logic          we;
   logic          wbank;
   logic [AW-1:0] waddr;
   logic [11:0]   wdata;
   logic          rd_bank;
   logic          rdd_i = 1'b0;
   logic          fd;
   logic          errp;
   logic [15:0]   errc;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_wr_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_video_tready (tready),
      .s_axis_video_tdata  (tdata),
      .s_axis_video_tvalid (tvalid),
      .s_axis_video_tuser  (tuser),
      .s_axis_video_tlast  (tlast),
      .mem_we              (we),
      .mem_wbank           (wbank),
      .mem_waddr           (waddr),
      .mem_wdata           (wdata),
      .rd_bank             (rd_bank),
      .rd_frame_done       (rdd_i),
      .frame_done          (fd),
      .err_pulse           (errp),
      .err_count           (errc),
      .busy                (busy)
   );

   function automatic logic [11:0] pack(input logic [23:0] d);
      return {d[23:20], d[15:12], d[7:4]};
   endfunction

   // Present one cycle of inputs, then let outputs settle past the edge.
   task automatic drive(input logic v, input logic u, input logic l,
                        input logic [23:0] d, input logic rdd);
      tvalid = v; tuser = u; tlast = l; tdata = d; rdd_i = rdd;
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(0, 0, 0, 24'h0, 0);
      drive(0, 0, 0, 24'h0, 0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1, 1, 0, 24'hFFFFFF, 1);
      drive(1, 1, 0, 24'hFFFFFF, 1);
      checks++;
      if (tready !== 1'b0 || we !== 1'b0 || waddr !== '0 || wdata !== '0 || rd_bank !== 1'b1 ||
          fd !== 1'b0 || errp !== 1'b0 || errc !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b we=%b addr=%0h data=%0h rdb=%b fd=%b ep=%b ec=%0d busy=%b exp 0 0 0 0 1 0 0 0 0",
                  tready, we, waddr, wdata, rd_bank, fd, errp, errc, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (tready !== 1'b1) begin
         errors++; $display("FAIL tready_after_reset got %b exp 1", tready);
      end
   endtask

   task automatic test_clean_frame();
      logic [23:0] d;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         d = 24'($urandom);
         drive(1, i == 0, (i % H) == H - 1, d, 0);
         checks++;
         if (we !== 1'b1 || waddr !== AW'(i) || wbank !== 1'b0 || wdata !== pack(d) ||
             fd !== (i == N - 1)) begin
            errors++;
            $display("FAIL clean_beat%0d got we=%b addr=%0d bank=%b data=%0h fd=%b exp 1 %0d 0 %0h %b",
                     i, we, waddr, wbank, wdata, fd, i, pack(d), i == N - 1);
         end
      end
      drive(0, 0, 0, 24'h0, 0);
      checks++;
      if (we !== 1'b0 || fd !== 1'b0 || rd_bank !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clean_after got we=%b fd=%b rdb=%b busy=%b exp 0 0 1 0", we, fd, rd_bank, busy);
      end
      drive(0, 0, 0, 24'h0, 1);
      checks++;
      if (rd_bank !== 1'b0) begin
         errors++; $display("FAIL clean_swap got rd_bank=%b exp 0", rd_bank);
      end
      drive(1, 1, 0, 24'h123456, 0);
      checks++;
      if (we !== 1'b1 || wbank !== 1'b1 || waddr !== '0) begin
         errors++;
         $display("FAIL clean_next_bank got we=%b bank=%b addr=%0d exp 1 1 0", we, wbank, waddr);
      end
   endtask

   task automatic test_pack();
      apply_reset();
      drive(1, 1, 0, 24'hA5C3F0, 0);
      checks++;
      if (we !== 1'b1 || wdata !== 12'hACF) begin
         errors++; $display("FAIL pack got we=%b data=%0h exp 1 acf", we, wdata);
      end
   endtask

   task automatic test_early_eol();
      apply_reset();
      drive(1, 1, 0, 24'h1, 0);
      drive(1, 0, 0, 24'h2, 0);
      drive(1, 0, 1, 24'h3, 0);
      checks++;
      if (errp !== 1'b1 || errc !== 16'd1 || we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL early_eol got ep=%b ec=%0d we=%b busy=%b exp 1 1 0 0", errp, errc, we, busy);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, i[0], 24'($urandom), 0);
         checks++;
         if (we !== 1'b0 || errp !== 1'b0) begin
            errors++; $display("FAIL early_drop%0d got we=%b ep=%b exp 0 0", i, we, errp);
         end
      end
      for (int i = 0; i < N; i++) begin
         drive(1, i == 0, (i % H) == H - 1, 24'($urandom), 0);
         checks++;
         if (we !== 1'b1 || waddr !== AW'(i) || fd !== (i == N - 1) || errc !== 16'd1) begin
            errors++;
            $display("FAIL early_recover%0d got we=%b addr=%0d fd=%b ec=%0d exp 1 %0d %b 1",
                     i, we, waddr, fd, errc, i, i == N - 1);
         end
      end
   endtask

   task automatic test_late_eol();
      apply_reset();
      for (int i = 0; i < H; i++) drive(1, i == 0, 0, 24'($urandom), 0);
      checks++;
      if (errp !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || errc !== 16'd1) begin
         errors++;
         $display("FAIL late_eol got ep=%b we=%b busy=%b ec=%0d exp 1 0 0 1", errp, we, busy, errc);
      end
      for (int i = 0; i < N; i++) begin
         drive(1, 0, (i % H) == H - 1, 24'($urandom), 0);
         checks++;
         if (we !== 1'b0 || fd !== 1'b0) begin
            errors++; $display("FAIL late_drop%0d got we=%b fd=%b exp 0 0", i, we, fd);
         end
      end
   endtask

   task automatic test_two_frames();
      apply_reset();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < N; i++) begin
            drive(1, i == 0, (i % H) == H - 1, 24'($urandom), 0);
            checks++;
            if (we !== 1'b1 || wbank !== 1'b0 || rd_bank !== 1'b1) begin
               errors++;
               $display("FAIL two_frames f%0d b%0d got we=%b bank=%b rdb=%b exp 1 0 1", f, i, we, wbank, rd_bank);
            end
         end
      end
      drive(0, 0, 0, 24'h0, 1);
      checks++;
      if (rd_bank !== 1'b0) begin
         errors++; $display("FAIL two_frames_swap got rd_bank=%b exp 0", rd_bank);
      end
      drive(0, 0, 0, 24'h0, 1);
      checks++;
      if (rd_bank !== 1'b0) begin
         errors++; $display("FAIL two_frames_noswap got rd_bank=%b exp 0", rd_bank);
      end
   endtask

   task automatic test_swap_sof();
      apply_reset();
      for (int i = 0; i < N; i++) drive(1, i == 0, (i % H) == H - 1, 24'($urandom), 0);
      drive(1, 1, 0, 24'h0F0F0F, 1);
      checks++;
      if (we !== 1'b1 || wbank !== 1'b1 || waddr !== '0 || rd_bank !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL swap_sof got we=%b bank=%b addr=%0d rdb=%b busy=%b exp 1 1 0 0 1",
                  we, wbank, waddr, rd_bank, busy);
      end
   endtask

   task automatic test_restart();
      apply_reset();
      drive(1, 1, 0, 24'h1, 0);
      drive(1, 0, 0, 24'h2, 0);
      drive(1, 1, 0, 24'h3, 0);
      checks++;
      if (errp !== 1'b1 || errc !== 16'd1 || we !== 1'b1 || waddr !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart got ep=%b ec=%0d we=%b addr=%0d busy=%b exp 1 1 1 0 1", errp, errc, we, waddr, busy);
      end
      for (int i = 1; i < N; i++) drive(1, 0, (i % H) == H - 1, 24'($urandom), 0);
      checks++;
      if (fd !== 1'b1 || waddr !== AW'(N - 1)) begin
         errors++; $display("FAIL restart_done got fd=%b addr=%0d exp 1 %0d", fd, waddr, N - 1);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 24'($urandom), 0);
      rst = 1'b1;
      drive(1, 0, 1, 24'h5, 0);
      checks++;
      if (we !== 1'b0 || busy !== 1'b0 || tready !== 1'b0) begin
         errors++; $display("FAIL mid_reset got we=%b busy=%b rdy=%b exp 0 0 0", we, busy, tready);
      end
      rst = 1'b0;
      for (int i = 3; i < N; i++) begin
         drive(1, 0, (i % H) == H - 1, 24'($urandom), 0);
         checks++;
         if (we !== 1'b0 || fd !== 1'b0) begin
            errors++; $display("FAIL mid_reset_after%0d got we=%b fd=%b exp 0 0", i, we, fd);
         end
      end
   endtask

   task automatic test_random();
      logic v, u, l, rdd, r, swp;
      logic [23:0] d;
      int sp, m_idx;
      logic m_in, m_full, m_wr, m_rd;
      logic [15:0] m_errc;
      logic e_we, e_fd, e_err, e_bank;
      logic [AW-1:0] e_addr;
      logic [11:0] e_data;
      apply_reset();
      sp = 0; m_idx = 0; m_in = 0; m_full = 0; m_wr = 0; m_rd = 1; m_errc = 0;
      e_bank = 0; e_addr = '0; e_data = '0;
      for (int c = 0; c < 3000; c++) begin
         v   = ($urandom % 4) != 0;
         u   = (sp == 0);
         l   = (sp % H) == H - 1;
         if ($urandom % 10 == 0) u = ~u;
         if ($urandom % 10 == 0) l = ~l;
         rdd = ($urandom % 5) == 0;
         r   = ($urandom % 250) == 0;
         d   = 24'($urandom);
         if (v) sp = (sp + 1) % N;
         rst = r;
         drive(v, u, l, d, rdd);
         e_we = 0; e_fd = 0; e_err = 0;
         if (r) begin
            m_idx = 0; m_in = 0; m_full = 0; m_wr = 0; m_rd = 1; m_errc = 0; sp = 0;
         end else begin
            swp = rdd && m_full && !m_in;
            if (swp) begin m_wr = ~m_wr; m_rd = ~m_rd; m_full = 0; end
            if (v) begin
               if (u) begin
                  if (m_in) e_err = 1; else m_full = 0;
                  e_we = 1; e_addr = '0; e_bank = m_wr; e_data = pack(d);
                  m_in = 1; m_idx = 1;
               end else if (m_in) begin
                  if (l != ((m_idx % H) == H - 1)) begin
                     e_err = 1; m_in = 0;
                  end else begin
                     e_we = 1; e_addr = AW'(m_idx); e_bank = m_wr; e_data = pack(d);
                     m_idx++;
                     if (m_idx == N) begin e_fd = 1; m_full = 1; m_in = 0; end
                  end
               end
            end
            if (e_err && m_errc != 16'hFFFF) m_errc++;
         end
         checks++;
         if (we !== e_we || (e_we && (waddr !== e_addr || wbank !== e_bank || wdata !== e_data ||
             wbank === rd_bank)) || fd !== e_fd || errp !== e_err || errc !== m_errc ||
             rd_bank !== m_rd || busy !== m_in || tready !== !r) begin
            errors++;
            $display("FAIL random c%0d got we=%b a=%0d bk=%b d=%0h fd=%b ep=%b ec=%0d rdb=%b busy=%b exp we=%b a=%0d bk=%b d=%0h fd=%b ep=%b ec=%0d rdb=%b busy=%b",
                     c, we, waddr, wbank, wdata, fd, errp, errc, rd_bank, busy,
                     e_we, e_addr, e_bank, e_data, e_fd, e_err, m_errc, m_rd, m_in);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_pack();
      test_early_eol();
      test_late_eol();
      test_two_frames();
      test_swap_sof();
      test_restart();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
